// File: rtl/decode_sequencer.sv
// Decode stage slot between fetch and execute. Classifies each instruction into a one-hot
// immediate-generator type and holds one decoded entry. An illegal opcode traps until cleared.
module decode_sequencer #(
  parameter int unsigned LEN     = 32,
  parameter int unsigned PC_LEN  = 32,
  parameter int unsigned CNT_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [LEN-1:0]     if_inst,
  input  logic [PC_LEN-1:0]  if_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [LEN-1:0]     id_inst,
  output logic [PC_LEN-1:0]  id_pc,
  output logic [5:0]         id_inst_type,
  output logic [4:0]         id_rd,
  output logic               id_reg_write,
  input  logic               flush,
  output logic               illegal,
  output logic [PC_LEN-1:0]  illegal_pc,
  input  logic               trap_clear,
  output logic [CNT_LEN-1:0] decode_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, TRAP} state_t;

  state_t              state_q, state_d;
  logic [LEN-1:0]      inst_q, inst_d;
  logic [PC_LEN-1:0]   pc_q, pc_d;
  logic [5:0]          type_q, type_d;
  logic [4:0]          rd_q, rd_d;
  logic                rw_q, rw_d;
  logic [PC_LEN-1:0]   ipc_q, ipc_d;
  logic [CNT_LEN-1:0]  cnt_q, cnt_d;

  logic [5:0] in_type;
  logic       in_legal;
  logic       accept;
  logic       handoff;

  always_comb begin
    in_type  = 6'b000010;
    in_legal = 1'b1;
    case (if_inst[6:0])
      7'b0110011:                                        in_type = 6'b000001;
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011:                            in_type = 6'b000010;
      7'b0100011:                                        in_type = 6'b000100;
      7'b1100011:                                        in_type = 6'b001000;
      7'b0110111, 7'b0010111:                            in_type = 6'b010000;
      7'b1101111:                                        in_type = 6'b100000;
      default:                                           in_legal = 1'b0;
    endcase
  end

  always_comb begin
    if_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        EMPTY:   if_ready = 1'b1;
        FULL:    if_ready = id_ready;
        default: if_ready = 1'b0;
      endcase
    end
  end

  assign id_valid = (state_q == FULL);
  assign illegal  = (state_q == TRAP);
  assign accept   = if_valid && if_ready && !flush;
  assign handoff  = id_valid && id_ready;

  // Flush takes priority over accept; a handoff in the same cycle still counts.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    type_d  = type_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ipc_d   = ipc_q;
    cnt_d   = handoff ? cnt_q + CNT_LEN'(1) : cnt_q;
    case (state_q)
      TRAP: begin
        if (trap_clear) state_d = EMPTY;
      end
      default: begin
        if (flush) begin
          state_d = EMPTY;
        end else if (accept && in_legal) begin
          state_d = FULL;
          inst_d  = if_inst;
          pc_d    = if_pc;
          type_d  = in_type;
          rd_d    = (in_type[2] || in_type[3]) ? 5'd0 : if_inst[11:7];
          rw_d    = !(in_type[2] || in_type[3]) && (if_inst[11:7] != 5'd0);
        end else if (accept) begin
          state_d = TRAP;
          ipc_d   = if_pc;
        end else if (handoff) begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      inst_q  <= '0;
      pc_q    <= '0;
      type_q  <= 6'b000010;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_inst      = inst_q;
  assign id_pc        = pc_q;
  assign id_inst_type = type_q;
  assign id_rd        = rd_q;
  assign id_reg_write = rw_q;
  assign illegal_pc   = ipc_q;
  assign decode_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with a 4-bit counter so wrap-around is reachable.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [5:0]  id_inst_type;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        flush;
  logic        illegal;
  logic [31:0] illegal_pc;
  logic        trap_clear;
  logic [3:0]  decode_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  decode_sequencer #(.LEN(32), .PC_LEN(32), .CNT_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_inst_type(id_inst_type), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .flush(flush), .illegal(illegal), .illegal_pc(illegal_pc),
    .trap_clear(trap_clear), .decode_cnt(decode_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] inst, input logic [5:0] typ,
                        input logic [4:0] rd, input logic rw);
    chk({tag, ".id_valid"}, 64'(id_valid), 64'(1));
    chk({tag, ".id_inst"}, 64'(id_inst), 64'(inst));
    chk({tag, ".type"}, 64'(id_inst_type), 64'(typ));
    chk({tag, ".rd"}, 64'(id_rd), 64'(rd));
    chk({tag, ".rw"}, 64'(id_reg_write), 64'(rw));
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    id_ready = 1'b0; flush = 1'b0; trap_clear = 1'b0;
    #1;
    chk("rst.if_ready", 64'(if_ready), 64'(0));
    chk("rst.id_valid", 64'(id_valid), 64'(0));
    chk("rst.type", 64'(id_inst_type), 64'(6'b000010));
    chk("rst.illegal", 64'(illegal), 64'(0));
    chk("rst.cnt", 64'(decode_cnt), 64'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("empty.if_ready", 64'(if_ready), 64'(1));

    // Back-to-back, one type per cycle
    if_valid = 1'b1; id_ready = 1'b1;
    if_inst = 32'h00500093; if_pc = 32'h0; tick();
    chk_id("b2b0", 32'h00500093, 6'b000010, 5'd1, 1'b1);
    chk("b2b0.cnt", 64'(decode_cnt), 64'(0));
    if_inst = 32'h00112023; if_pc = 32'h4; tick();
    chk_id("b2b1", 32'h00112023, 6'b000100, 5'd0, 1'b0);
    chk("b2b1.cnt", 64'(decode_cnt), 64'(1));
    if_inst = 32'hFE000EE3; if_pc = 32'h8; tick();
    chk_id("b2b2", 32'hFE000EE3, 6'b001000, 5'd0, 1'b0);
    if_inst = 32'h000120B7; if_pc = 32'hC; tick();
    chk_id("b2b3", 32'h000120B7, 6'b010000, 5'd1, 1'b1);
    if_inst = 32'h008000EF; if_pc = 32'h10; tick();
    chk_id("b2b4", 32'h008000EF, 6'b100000, 5'd1, 1'b1);
    chk("b2b4.pc", 64'(id_pc), 64'(32'h10));
    chk("b2b4.cnt", 64'(decode_cnt), 64'(4));
    if_valid = 1'b0; tick();
    chk("b2b.drain.valid", 64'(id_valid), 64'(0));
    chk("b2b.drain.cnt", 64'(decode_cnt), 64'(5));
    chk("b2b.drain.type_held", 64'(id_inst_type), 64'(6'b100000));

    // Stall with a different instruction waiting at fetch
    if_valid = 1'b1; id_ready = 1'b0; if_inst = 32'h002081B3; if_pc = 32'h40; tick();
    if_inst = 32'h00000013; if_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      chk_id("stall", 32'h002081B3, 6'b000001, 5'd3, 1'b1);
      chk("stall.if_ready", 64'(if_ready), 64'(0));
      chk("stall.pc", 64'(id_pc), 64'(32'h40));
      chk("stall.cnt", 64'(decode_cnt), 64'(5));
      tick();
    end
    if_valid = 1'b0; id_ready = 1'b1; #1;
    chk("stall.release.if_ready", 64'(if_ready), 64'(1));
    tick();
    chk("stall.done.valid", 64'(id_valid), 64'(0));
    chk("stall.done.cnt", 64'(decode_cnt), 64'(6));

    // Illegal opcode traps; flush ignored in TRAP
    if_valid = 1'b1; id_ready = 1'b0; if_inst = 32'h0000007F; if_pc = 32'h100; tick();
    chk("trap.illegal", 64'(illegal), 64'(1));
    chk("trap.ipc", 64'(illegal_pc), 64'(32'h100));
    chk("trap.if_ready", 64'(if_ready), 64'(0));
    chk("trap.id_valid", 64'(id_valid), 64'(0));
    chk("trap.id_inst_held", 64'(id_inst), 64'(32'h002081B3));
    chk("trap.type_held", 64'(id_inst_type), 64'(6'b000001));
    if_inst = 32'h00500093; flush = 1'b1; tick();
    chk("trap.flush.illegal", 64'(illegal), 64'(1));
    flush = 1'b0; if_valid = 1'b0; trap_clear = 1'b1; tick();
    trap_clear = 1'b0;
    chk("clear.illegal", 64'(illegal), 64'(0));
    chk("clear.if_ready", 64'(if_ready), 64'(1));
    chk("clear.ipc_held", 64'(illegal_pc), 64'(32'h100));

    // Flush while stalled drops held and incoming entries
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h200; tick();
    if_inst = 32'h00112023; if_pc = 32'h204; flush = 1'b1; tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush.valid", 64'(id_valid), 64'(0));
    chk("flush.if_ready", 64'(if_ready), 64'(1));
    chk("flush.cnt", 64'(decode_cnt), 64'(6));
    chk("flush.inst_held", 64'(id_inst), 64'(32'h00500093));

    // Flush with id_ready still counts the handoff
    if_valid = 1'b1; if_pc = 32'h208; tick();
    if_valid = 1'b0; flush = 1'b1; id_ready = 1'b1; tick();
    flush = 1'b0;
    chk("flush_ho.valid", 64'(id_valid), 64'(0));
    chk("flush_ho.cnt", 64'(decode_cnt), 64'(7));

    // Handoff plus illegal accept in FULL
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h2FC; tick();
    if_inst = 32'h0000007F; if_pc = 32'h300; tick();
    if_valid = 1'b0;
    chk("ho_ill.cnt", 64'(decode_cnt), 64'(8));
    chk("ho_ill.illegal", 64'(illegal), 64'(1));
    chk("ho_ill.ipc", 64'(illegal_pc), 64'(32'h300));
    chk("ho_ill.valid", 64'(id_valid), 64'(0));
    trap_clear = 1'b1; tick(); trap_clear = 1'b0;

    // Reset mid-stream while FULL and stalled
    id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h002081B3; if_pc = 32'h400; tick();
    chk("pre_rst.valid", 64'(id_valid), 64'(1));
    rst = 1'b1; #1;
    chk("mrst.valid", 64'(id_valid), 64'(0));
    chk("mrst.if_ready", 64'(if_ready), 64'(0));
    chk("mrst.inst", 64'(id_inst), 64'(0));
    chk("mrst.pc", 64'(id_pc), 64'(0));
    chk("mrst.type", 64'(id_inst_type), 64'(6'b000010));
    chk("mrst.rd", 64'(id_rd), 64'(0));
    chk("mrst.ipc", 64'(illegal_pc), 64'(0));
    tick();
    rst = 1'b0; if_valid = 1'b0; #1;
    chk("mrst.cnt", 64'(decode_cnt), 64'(0));

    // Counter wrap: 17 handoffs on a 4-bit counter
    if_valid = 1'b1; id_ready = 1'b1; if_inst = 32'h00500093;
    for (int i = 0; i < 17; i++) begin
      if_pc = 32'(i * 4);
      tick();
    end
    chk("wrap.cnt16", 64'(decode_cnt), 64'(0));
    if_valid = 1'b0; tick();
    chk("wrap.cnt17", 64'(decode_cnt), 64'(1));
    chk("wrap.valid", 64'(id_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
Sits between instruction fetch and execute. It owns the single shared immediate generator: it classifies each fetched instruction into the one-hot instruction type, drives that type and the instruction to the generator, and registers the decoded bundle. It uses a one-entry valid/ready pipeline slot with flush and an illegal-instruction trap state, so the immediate generator only ever sees a legal one-hot type.

Parameters:
LEN, 32, instruction and datapath width
PC_LEN, 32, program counter width
CNT_LEN, 32, width of the retired-decode counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_valid  in  1  fetch presents an instruction
if_ready  out  1  sequencer accepts this cycle
if_inst  in  LEN  fetched instruction
if_pc  in  PC_LEN  PC of fetched instruction
id_valid  out  1  decoded slot holds a valid entry
id_ready  in  1  execute consumes the entry
id_inst  out  LEN  registered instruction, also fed to the immediate generator
id_pc  out  PC_LEN  registered PC
id_inst_type  out  6  one-hot type to the immediate generator: bit0 R, bit1 I, bit2 S, bit3 B, bit4 U, bit5 J
id_rd  out  5  inst[11:7]; 0 for S and B types
id_reg_write  out  1  1 for R, I, U, J types with rd!=0
flush  in  1  discard the held entry and any incoming entry this cycle
illegal  out  1  high while in TRAP
illegal_pc  out  PC_LEN  PC of the offending instruction
trap_clear  in  1  leave TRAP
decode_cnt  out  CNT_LEN  count of entries handed to execute

Behaviour:
- Reset (async, rst=1) sets: state EMPTY; id_valid=0; if_ready=0 while rst is high; id_inst=0; id_pc=0; id_inst_type=6'b000010 (I, never all-zero); id_rd=0; id_reg_write=0; illegal=0; illegal_pc=0; decode_cnt=0.
- Opcode classification on inst[6:0]:
  - 0110011 -> R
  - 0000011, 0010011, 1100111, 0001111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - Any other opcode is illegal.
- States:
  - EMPTY: if_ready=1, id_valid=0.
  - FULL: id_valid=1, if_ready=id_ready (pass-through; back-to-back one per cycle).
  - TRAP: if_ready=0, id_valid=0, illegal=1.
- Accept occurs when if_valid&&if_ready&&!flush.
  - Legal accept: load id_* on that edge. id_* outputs are visible the next cycle (1-cycle latency). State becomes FULL.
  - Illegal accept: nothing is loaded into id_*. illegal_pc<=if_pc, state becomes TRAP.
- FULL && id_ready && no accept: state becomes EMPTY.
- Handoff occurs when id_valid&&id_ready. Each handoff increments decode_cnt by 1, wrapping modulo 2^CNT_LEN.
- id_* outputs must hold stable while id_valid&&!id_ready.
- flush=1:
  - Next state is EMPTY from EMPTY or FULL; the held entry is dropped and the incoming instruction is not accepted.
  - A held entry with id_ready=1 in the same cycle still counts as a handoff (execute already took it).
  - In TRAP, flush has no effect.
- TRAP is left only by trap_clear=1, going to EMPTY. trap_clear in other states is ignored. illegal_pc holds until the next illegal accept.
- Simultaneous handoff and legal accept in FULL: the new entry replaces the old one, state stays FULL, decode_cnt+1.
- Simultaneous handoff and illegal accept in FULL: decode_cnt+1, state becomes TRAP, id_valid drops next cycle.
- id_inst_type is always exactly one-hot. It retains its last legal value in EMPTY and TRAP.

Test Plan:
- Reset mid-stream: assert rst with FULL, id_ready=0 -> outputs return immediately to reset values, and decode_cnt=0 on deassert.
- Back-to-back: if_valid=1, id_ready=1, if_inst 0x00500093, 0x00112023, 0xFE000EE3, 0x000120B7, 0x008000EF -> id_inst_type 000010, 000100, 001000, 010000, 100000 on consecutive cycles, id_reg_write 1,0,0,1,1, decode_cnt=5.
- Stall: accept 0x002081B3 with id_ready=0 for 3 cycles -> id_valid=1, id_inst_type=000001, id_rd=3, if_ready=0, outputs stable; id_ready=1 -> one handoff, decode_cnt+1.
- Illegal: if_inst=0x0000007F at pc 0x100 -> next cycle illegal=1, illegal_pc=0x100, if_ready=0; trap_clear -> EMPTY, if_ready=1.
- Flush: FULL with id_ready=0, flush=1 and if_valid=1 in the same cycle -> next cycle id_valid=0, state EMPTY, decode_cnt unchanged.
- Counter wrap: CNT_LEN=4, 17 handoffs -> decode_cnt=1.
